// File: rtl/mem_copy_pkg.sv
// Shared types and defaults for the block copier: FSM states, access size, default widths.
package mem_copy_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 16;
  localparam int unsigned DEFAULT_DATA_W = 32;
  localparam int unsigned DEFAULT_LEN_W  = 9;

  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/mem_copy_csum.sv
// Running modulo-2^DATA_W sum of written words; cleared when a new copy is accepted.
module mem_copy_csum #(
  parameter int unsigned DATA_W = mem_copy_pkg::DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              add_en_i,
  input  logic [DATA_W-1:0] add_data_i,
  output logic [DATA_W-1:0] sum_o
);

  logic [DATA_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clear_i) begin
      sum_d = '0;
    end else if (add_en_i) begin
      sum_d = sum_q + add_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/mem_block_copier.sv
// Pipelined word-block copier: one read per clock, each write trailing its read data by one capture.
// Optional checksum accumulator enabled by MEM_BLOCK_COPIER_CHECKSUM_EN.
module mem_block_copier
  import mem_copy_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W = DEFAULT_DATA_W,
  parameter int unsigned LEN_W  = DEFAULT_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic              mem_ren,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wen,
  output logic [1:0]        mem_sizes,
  output logic [DATA_W-1:0] checksum
);

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ren_q, ren_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [LEN_W-1:0]  rd_left_q, rd_left_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              pend_q, pend_d;

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ren_d     = ren_q;
    raddr_d   = raddr_q;
    wen_d     = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    rd_left_d = rd_left_q;
    wr_addr_d = wr_addr_q;
    // A read sampled by memory this edge returns data to capture on the next edge.
    pend_d    = ren_q;

    if (pend_q) begin
      wen_d     = 1'b1;
      wdata_d   = mem_rdata;
      waddr_d   = wr_addr_q;
      wr_addr_d = wr_addr_q + ADDR_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          wr_addr_d = dst_addr;
          if (len == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d   = READ;
            ren_d     = 1'b1;
            raddr_d   = src_addr;
            rd_left_d = len - LEN_W'(1);
            busy_d    = 1'b1;
          end
        end
      end
      READ: begin
        if (rd_left_q == '0) begin
          ren_d   = 1'b0;
          state_d = DRAIN;
        end else begin
          raddr_d   = raddr_q + ADDR_W'(1);
          rd_left_d = rd_left_q - LEN_W'(1);
        end
      end
      DRAIN: begin
        // Leave only once the final write has been on the bus for a full cycle.
        if (!pend_q && !wen_q) begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ren_q     <= 1'b0;
      raddr_q   <= '0;
      wen_q     <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      rd_left_q <= '0;
      wr_addr_q <= '0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ren_q     <= ren_d;
      raddr_q   <= raddr_d;
      wen_q     <= wen_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      rd_left_q <= rd_left_d;
      wr_addr_q <= wr_addr_d;
      pend_q    <= pend_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mem_ren   = ren_q;
  assign mem_raddr = raddr_q;
  assign mem_wen   = wen_q;
  assign mem_waddr = waddr_q;
  assign mem_wdata = wdata_q;
  assign mem_sizes = SIZE_WORD;

`ifdef MEM_BLOCK_COPIER_CHECKSUM_EN
  logic csum_clear_c;

  assign csum_clear_c = (state_q == IDLE) && start;

  mem_copy_csum #(
    .DATA_W(DATA_W)
  ) u_csum (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (csum_clear_c),
    .add_en_i  (wen_q),
    .add_data_i(wdata_q),
    .sum_o     (checksum)
  );
`else
  assign checksum = '0;
`endif

endmodule
